s2p_input: RTL and testbench

- Serial-to-parallel front end of the MSDAP datapath. It sits directly upstream of the Control FSM and the data memory.
- Deserializes the two serial input channels (left/right) into 16-bit words, aligned to the frame sync pulse.
- Pulses s2p_done once per received word pair.
- Tracks runs of consecutive all-zero samples and drives the all_zeros sleep indication consumed by Control.

---
 rtl/s2p_input_if.sv | 26 ++
 rtl/s2p_input.sv | 116 +++++++++++
 tb/tb_s2p_input.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/s2p_input_if.sv
// Handshake and data bundle between the serial source/Control and the s2p front end.
// The master side drives the serial stream and control; the slave side (s2p_input) returns the words.
interface s2p_input_if #(
   parameter int WORD_W = 16
);
   logic              s2p_clear;
   logic              in_ready;
   logic              bit_en;
   logic              frame;
   logic              in_l;
   logic              in_r;
   logic [WORD_W-1:0] data_l;
   logic [WORD_W-1:0] data_r;
   logic              s2p_done;
   logic              all_zeros;

   modport master (
      output s2p_clear, in_ready, bit_en, frame, in_l, in_r,
      input  data_l, data_r, s2p_done, all_zeros
   );

   modport slave (
      input  s2p_clear, in_ready, bit_en, frame, in_l, in_r,
      output data_l, data_r, s2p_done, all_zeros
   );
endinterface

// File: rtl/s2p_input.sv
// Serial-to-parallel front end: deserializes left/right channels into frame-aligned words
// and tracks long runs of all-zero word pairs for the sleep indication.
module s2p_input #(
   parameter int WORD_W   = 16,
   parameter int ZERO_RUN = 800,
   parameter int ZCNT_W   = 10
) (
   input logic        clk,
   input logic        reset_n,
   s2p_input_if.slave bus
);
   localparam int CNT_W = $clog2(WORD_W);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] sh_l_q, sh_l_d;
   logic [WORD_W-1:0] sh_r_q, sh_r_d;
   logic [WORD_W-1:0] data_l_q, data_l_d;
   logic [WORD_W-1:0] data_r_q, data_r_d;
   logic [ZCNT_W-1:0] zero_run_q, zero_run_d;
   logic              done_q, done_d;
   logic              all_zeros_q, all_zeros_d;

   logic              accepted;
   logic [WORD_W-1:0] word_l;
   logic [WORD_W-1:0] word_r;

   assign accepted = bus.in_ready && bus.bit_en;
   assign word_l   = {sh_l_q[WORD_W-2:0], bus.in_l};
   assign word_r   = {sh_r_q[WORD_W-2:0], bus.in_r};

   // Clear beats everything; losing in_ready mid-word aborts before any bit is considered.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sh_l_d     = sh_l_q;
      sh_r_d     = sh_r_q;
      data_l_d   = data_l_q;
      data_r_d   = data_r_q;
      zero_run_d = zero_run_q;
      done_d     = 1'b0;

      if (bus.s2p_clear) begin
         state_d    = IDLE;
         bit_cnt_d  = '0;
         sh_l_d     = '0;
         sh_r_d     = '0;
         data_l_d   = '0;
         data_r_d   = '0;
         zero_run_d = '0;
      end else if (state_q == SHIFT && !bus.in_ready) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
      end else if (accepted) begin
         if (bus.frame) begin
            sh_l_d    = {{(WORD_W-1){1'b0}}, bus.in_l};
            sh_r_d    = {{(WORD_W-1){1'b0}}, bus.in_r};
            bit_cnt_d = CNT_W'(1);
            state_d   = SHIFT;
         end else if (state_q == SHIFT) begin
            sh_l_d = word_l;
            sh_r_d = word_r;
            if (bit_cnt_q == CNT_W'(WORD_W-1)) begin
               data_l_d  = word_l;
               data_r_d  = word_r;
               done_d    = 1'b1;
               state_d   = IDLE;
               bit_cnt_d = '0;
               // Saturate so a long silence never wraps back below the threshold.
               if (word_l == '0 && word_r == '0) begin
                  zero_run_d = (zero_run_q >= ZCNT_W'(ZERO_RUN)) ? ZCNT_W'(ZERO_RUN)
                                                                 : zero_run_q + ZCNT_W'(1);
               end else begin
                  zero_run_d = '0;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
      end

      all_zeros_d = (zero_run_d == ZCNT_W'(ZERO_RUN));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         sh_l_q      <= '0;
         sh_r_q      <= '0;
         data_l_q    <= '0;
         data_r_q    <= '0;
         zero_run_q  <= '0;
         done_q      <= 1'b0;
         all_zeros_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         sh_l_q      <= sh_l_d;
         sh_r_q      <= sh_r_d;
         data_l_q    <= data_l_d;
         data_r_q    <= data_r_d;
         zero_run_q  <= zero_run_d;
         done_q      <= done_d;
         all_zeros_q <= all_zeros_d;
      end
   end

   assign bus.data_l    = data_l_q;
   assign bus.data_r    = data_r_q;
   assign bus.s2p_done  = done_q;
   assign bus.all_zeros = all_zeros_q;
endmodule

// File: tb/tb_s2p_input.sv
// Randomized bench for s2p_input: a word-level reference model queues expected pairs,
// and an independent monitor checks them whenever s2p_done pulses.
module tb_s2p_input;
   localparam int WORD_W   = 16;
   localparam int ZERO_RUN = 800;

   logic clk;
   logic reset_n;

   s2p_input_if #(.WORD_W(WORD_W)) bus ();

   s2p_input #(
      .WORD_W  (WORD_W),
      .ZERO_RUN(ZERO_RUN),
      .ZCNT_W  (10)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WORD_W-1:0] l;
      logic [WORD_W-1:0] r;
      logic              az;
   } exp_t;

   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;

   // Reference model: a word is a list of accepted bits starting at a frame bit.
   bit                m_active;
   int                m_nbits;
   logic [WORD_W-1:0] m_wl;
   logic [WORD_W-1:0] m_wr;
   int                m_zrun;

   function automatic void check_output(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      m_active = 1'b0;
      m_nbits  = 0;
      m_wl     = '0;
      m_wr     = '0;
      m_zrun   = 0;
      sb_q.delete();
   endfunction

   function automatic void model_step(logic be, logic fr, logic l, logic r, logic rdy, logic clr);
      exp_t e;
      if (clr) begin
         m_active = 1'b0;
         m_nbits  = 0;
         m_zrun   = 0;
      end else if (!rdy) begin
         m_active = 1'b0;
      end else if (be) begin
         if (fr) begin
            m_active = 1'b1;
            m_nbits  = 1;
            m_wl     = WORD_W'(l);
            m_wr     = WORD_W'(r);
         end else if (m_active) begin
            m_wl    = (m_wl << 1) | WORD_W'(l);
            m_wr    = (m_wr << 1) | WORD_W'(r);
            m_nbits = m_nbits + 1;
            if (m_nbits == WORD_W) begin
               if (m_wl == 0 && m_wr == 0) m_zrun = (m_zrun < ZERO_RUN) ? m_zrun + 1 : ZERO_RUN;
               else                        m_zrun = 0;
               e.l  = m_wl;
               e.r  = m_wr;
               e.az = (m_zrun == ZERO_RUN);
               sb_q.push_back(e);
               m_active = 1'b0;
            end
         end
      end
   endfunction

   // Drives one clock cycle of stimulus, informs the model, and returns just after the edge.
   task automatic apply_stimulus(input logic be, input logic fr, input logic l, input logic r,
                                 input logic rdy, input logic clr);
      bus.bit_en    = be;
      bus.frame     = fr;
      bus.in_l      = l;
      bus.in_r      = r;
      bus.in_ready  = rdy;
      bus.s2p_clear = clr;
      model_step(be, fr, l, r, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++)
         apply_stimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
   endtask

   task automatic send_bits(input logic [WORD_W-1:0] l, input logic [WORD_W-1:0] r,
                            input int nbits, input int gap);
      for (int i = 0; i < nbits; i++) begin
         apply_stimulus(1'b1, (i == 0), l[WORD_W-1-i], r[WORD_W-1-i], 1'b1, 1'b0);
         idle_cycles(gap);
      end
   endtask

   task automatic send_word(input logic [WORD_W-1:0] l, input logic [WORD_W-1:0] r, input int gap);
      send_bits(l, r, WORD_W, gap);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 4 && sb_q.size() != 0; i++) idle_cycles(1);
      idle_cycles(1);
      check_output(name, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_all_zero_outputs(input string tag);
      check_output({tag, "_data_l"}, 32'(bus.data_l), 32'd0);
      check_output({tag, "_data_r"}, 32'(bus.data_r), 32'd0);
      check_output({tag, "_done"}, 32'(bus.s2p_done), 32'd0);
      check_output({tag, "_all_zeros"}, 32'(bus.all_zeros), 32'd0);
   endtask

   // Monitor: every s2p_done must match the oldest expected pair.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.s2p_done !== 1'b0) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got s2p_done=%b expected 0 at %0t", bus.s2p_done, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_output("sb_data_l", 32'(bus.data_l), 32'(e.l));
            check_output("sb_data_r", 32'(bus.data_r), 32'(e.r));
            check_output("sb_all_zeros", 32'(bus.all_zeros), 32'(e.az));
         end
      end
   end

   initial begin
      reset_n       = 1'b0;
      bus.s2p_clear = 1'b0;
      bus.in_ready  = 1'b0;
      bus.bit_en    = 1'b0;
      bus.frame     = 1'b0;
      bus.in_l      = 1'b0;
      bus.in_r      = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero_outputs("reset");
      reset_n = 1'b1;
      idle_cycles(2);

      $display("[TB] basic word, bit_en every 4th cycle");
      send_word(16'hA5C3, 16'h1234, 3);
      drain("drain_basic");

      $display("[TB] in_ready low, then unframed bits");
      for (int i = 0; i < 5; i++) apply_stimulus(1'b1, (i == 0), 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) apply_stimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      send_word(16'h8001, 16'h7FFE, 1);
      drain("drain_ready");

      $display("[TB] realign after 7 bits");
      send_bits(16'h1357, 16'h2468, 7, 0);
      send_word(16'hFFFF, 16'h0000, 0);
      drain("drain_realign");

      $display("[TB] random cycles");
      for (int i = 0; i < 400; i++)
         apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                        1'($urandom), 1'($urandom), ($urandom_range(0, 19) != 0), 1'b0);
      for (int i = 0; i < 30; i++)
         send_word(WORD_W'($urandom), WORD_W'($urandom), $urandom_range(0, 2));
      drain("drain_random");

      $display("[TB] zero run to threshold and beyond");
      for (int i = 0; i < ZERO_RUN + 5; i++) send_word('0, '0, 0);
      drain("drain_zero");
      check_output("az_held", 32'(bus.all_zeros), 32'd1);
      send_word(16'h0001, 16'h0000, 0);
      drain("drain_wake");
      check_output("az_dropped", 32'(bus.all_zeros), 32'd0);

      $display("[TB] zero run broken one short");
      for (int i = 0; i < ZERO_RUN - 1; i++) send_word('0, '0, 0);
      send_word(WORD_W'($urandom_range(1, 65535)), WORD_W'($urandom), 0);
      for (int i = 0; i < ZERO_RUN - 1; i++) send_word('0, '0, 0);
      drain("drain_short");
      check_output("az_never", 32'(bus.all_zeros), 32'd0);

      $display("[TB] s2p_clear mid-word while asleep");
      send_word(16'h00F0, 16'h0F00, 0);
      for (int i = 0; i < ZERO_RUN; i++) send_word('0, '0, 0);
      drain("drain_pre_clear");
      check_output("az_before_clear", 32'(bus.all_zeros), 32'd1);
      send_bits(16'hC3C3, 16'h3C3C, 8, 0);
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_all_zero_outputs("clear");
      for (int i = 0; i < WORD_W; i++) apply_stimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      send_word(16'hBEEF, 16'h0042, 0);
      drain("drain_clear");

      $display("[TB] reset_n mid-word while asleep");
      for (int i = 0; i < ZERO_RUN; i++) send_word('0, '0, 0);
      drain("drain_pre_reset");
      check_output("az_before_reset", 32'(bus.all_zeros), 32'd1);
      send_bits(16'h5A5A, 16'hA5A5, 8, 0);
      bus.bit_en = 1'b1;
      bus.frame  = 1'b0;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all_zero_outputs("async_reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < WORD_W; i++) apply_stimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      send_word(16'h0F0F, 16'hF00F, 2);
      drain("drain_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
